// File: rtl/automorphism_pkg.sv
// Shared types and default sizing for the Galois automorphism BRAM controller.
// HLEN_DEF is the default bank address width; the other constants follow from it.
package automorphism_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      AUTO = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam int HLEN_DEF = 7;
   localparam int DEPTH    = 1 << HLEN_DEF;
   localparam int N        = 2 * DEPTH;
   localparam int KW       = HLEN_DEF + 2;

   function automatic int depth_of(input int hlen);
      return 1 << hlen;
   endfunction

endpackage

// File: rtl/mod_negate.sv
// Modular negation of one coefficient: zero stays zero, otherwise modulus - x.
module mod_negate #(
   parameter int DLEN = 32
) (
   input  logic [DLEN-1:0] modulus,
   input  logic [DLEN-1:0] x,
   output logic [DLEN-1:0] y
);

   assign y = (x == '0) ? '0 : (modulus - x);

endmodule

// File: rtl/automorphism_bram_ctrl.sv
// Applies the negacyclic Galois automorphism X -> X^k to a coefficient vector.
// Banks 0/1 hold the even/odd input halves, banks 2/3 hold the even/odd permuted result.
module automorphism_bram_ctrl
   import automorphism_pkg::*;
#(
   parameter int DLEN = 32,
   parameter int HLEN = HLEN_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [HLEN+1:0]   galois_k,
   input  logic [DLEN-1:0]   modulus,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DLEN-1:0]   in_even,
   input  logic [DLEN-1:0]   in_odd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DLEN-1:0]   out_even,
   output logic [DLEN-1:0]   out_odd,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [3:0]        bram_en,
   output logic [3:0]        bram_we,
   output logic [HLEN-1:0]   bram_addr_a [4],
   output logic [HLEN-1:0]   bram_addr_b [4],
   output logic [DLEN-1:0]   bram_di_a [4],
   output logic [DLEN-1:0]   bram_di_b [4],
   input  logic [DLEN-1:0]   bram_do_a [4],
   output logic              bram_rst
);

   localparam int               BANK_DEPTH  = depth_of(HLEN);
   localparam logic [HLEN-1:0]  LAST_J      = '1;
   localparam logic [HLEN+1:0]  AUTO_RD_END = (HLEN+2)'(BANK_DEPTH);
   localparam logic [HLEN+1:0]  AUTO_LAST   = (HLEN+2)'(BANK_DEPTH + 1);
   localparam logic [HLEN:0]    DEPTH_P     = (HLEN+1)'(BANK_DEPTH);

   state_t            state;
   logic [HLEN+1:0]   k_q;
   logic [DLEN-1:0]   mod_q;
   logic [HLEN-1:0]   wr_cnt;
   logic [HLEN+1:0]   auto_cnt;
   logic [HLEN+1:0]   p_even;
   logic [HLEN+1:0]   p_odd;
   logic              wr_valid;
   logic [DLEN-1:0]   wr_data_e;
   logic [DLEN-1:0]   wr_data_o;
   logic [HLEN-1:0]   wr_addr_e;
   logic [HLEN-1:0]   wr_addr_o;
   logic [HLEN:0]     rd_ptr;
   logic [HLEN-1:0]   out_cnt;
   logic [DLEN-1:0]   neg_e;
   logic [DLEN-1:0]   neg_o;
   logic [HLEN+1:0]   step;
   logic              capture;
   logic              advance;

   // Destination indices live modulo 2N, which is exactly the natural wrap of HLEN+2 bits.
   assign step    = {k_q[HLEN:0], 1'b0};
   assign capture = (auto_cnt != '0) && (auto_cnt <= AUTO_RD_END);
   assign advance = !out_valid || out_ready;

   mod_negate #(.DLEN(DLEN)) u_neg_even (
      .modulus (mod_q),
      .x       (bram_do_a[0]),
      .y       (neg_e)
   );

   mod_negate #(.DLEN(DLEN)) u_neg_odd (
      .modulus (mod_q),
      .x       (bram_do_a[1]),
      .y       (neg_o)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         k_q       <= '0;
         mod_q     <= '0;
         wr_cnt    <= '0;
         auto_cnt  <= '0;
         p_even    <= '0;
         p_odd     <= '0;
         wr_valid  <= 1'b0;
         wr_data_e <= '0;
         wr_data_o <= '0;
         wr_addr_e <= '0;
         wr_addr_o <= '0;
         rd_ptr    <= '0;
         out_cnt   <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (galois_k[0]) begin
                     k_q      <= galois_k;
                     mod_q    <= modulus;
                     wr_cnt   <= '0;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                     state    <= LOAD;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (in_valid && in_ready) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == LAST_J) begin
                     in_ready <= 1'b0;
                     auto_cnt <= '0;
                     p_even   <= '0;
                     p_odd    <= k_q;
                     wr_valid <= 1'b0;
                     state    <= AUTO;
                  end
               end
            end
            AUTO: begin
               // Second pipeline stage: fold indices >= N back into range with a negation.
               auto_cnt <= auto_cnt + 1'b1;
               wr_valid <= capture;
               if (capture) begin
                  wr_data_e <= p_even[HLEN+1] ? neg_e : bram_do_a[0];
                  wr_data_o <= p_odd[HLEN+1]  ? neg_o : bram_do_a[1];
                  wr_addr_e <= p_even[HLEN:1];
                  wr_addr_o <= p_odd[HLEN:1];
                  p_even    <= p_even + step;
                  p_odd     <= p_odd + step;
               end
               if (auto_cnt == AUTO_LAST) begin
                  wr_valid  <= 1'b0;
                  rd_ptr    <= '0;
                  out_cnt   <= '0;
                  out_valid <= 1'b0;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (advance) begin
                  if (rd_ptr < DEPTH_P) begin
                     rd_ptr <= rd_ptr + 1'b1;
                  end
                  out_valid <= (rd_ptr < DEPTH_P);
               end
               if (out_valid && out_ready) begin
                  out_cnt <= out_cnt + 1'b1;
                  if (out_cnt == LAST_J) begin
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bram_rst <= 1'b1;
      end else begin
         bram_rst <= 1'b0;
      end
   end

   // Bank strobes decode straight from the registered state so writes never leak across phases.
   always_comb begin
      bram_en = '0;
      bram_we = '0;
      for (int b = 0; b < 4; b++) begin
         bram_addr_a[b] = '0;
         bram_di_a[b]   = '0;
      end
      case (state)
         LOAD: begin
            if (in_valid && in_ready) begin
               bram_en[1:0]   = 2'b11;
               bram_we[1:0]   = 2'b11;
               bram_addr_a[0] = wr_cnt;
               bram_addr_a[1] = wr_cnt;
               bram_di_a[0]   = in_even;
               bram_di_a[1]   = in_odd;
            end
         end
         AUTO: begin
            if (auto_cnt < AUTO_RD_END) begin
               bram_en[1:0]   = 2'b11;
               bram_addr_a[0] = auto_cnt[HLEN-1:0];
               bram_addr_a[1] = auto_cnt[HLEN-1:0];
            end
            if (wr_valid) begin
               bram_en[3:2]   = 2'b11;
               bram_we[3:2]   = 2'b11;
               bram_addr_a[2] = wr_addr_e;
               bram_addr_a[3] = wr_addr_o;
               bram_di_a[2]   = wr_data_e;
               bram_di_a[3]   = wr_data_o;
            end
         end
         OUT: begin
            if (advance) begin
               bram_en[3:2]   = 2'b11;
               bram_addr_a[2] = rd_ptr[HLEN-1:0];
               bram_addr_a[3] = rd_ptr[HLEN-1:0];
            end
         end
         default: begin
         end
      endcase
   end

   assign bram_addr_b = bram_addr_a;
   assign bram_di_b   = bram_di_a;
   assign out_even    = bram_do_a[2];
   assign out_odd     = bram_do_a[3];

endmodule

// File: tb/tb_automorphism_bram_ctrl.sv
// Randomized scoreboard bench for automorphism_bram_ctrl with behavioural BRAM banks
// and a reference model computing X^i -> X^(i*k) mod (X^N + 1) directly.
module tb_automorphism_bram_ctrl;
   import automorphism_pkg::*;

   localparam int DW = 32;

   typedef struct packed {
      logic [DW-1:0] ev;
      logic [DW-1:0] od;
   } pair_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [KW-1:0]     galois_k = '0;
   logic [DW-1:0]     modulus = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DW-1:0]     in_even = '0;
   logic [DW-1:0]     in_odd = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DW-1:0]     out_even;
   logic [DW-1:0]     out_odd;
   logic              busy;
   logic              done;
   logic              err;
   logic [3:0]        bram_en;
   logic [3:0]        bram_we;
   logic [HLEN_DEF-1:0] bram_addr_a [4];
   logic [HLEN_DEF-1:0] bram_addr_b [4];
   logic [DW-1:0]     bram_di_a [4];
   logic [DW-1:0]     bram_di_b [4];
   logic [DW-1:0]     bram_do_a [4];
   logic              bram_rst;

   int                compared = 0;
   int                mismatched = 0;
   int                err_seen = 0;
   int                expected_err = 0;
   int                ready_mode = 0;
   int                cap_idx = 0;
   logic [DW-1:0]     coef [N];
   logic [DW-1:0]     cap [N];
   logic [DW-1:0]     mem [4][DEPTH];
   pair_t             exp_q [$];

   automorphism_bram_ctrl #(.DLEN(DW), .HLEN(HLEN_DEF)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .galois_k    (galois_k),
      .modulus     (modulus),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_even     (in_even),
      .in_odd      (in_odd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_even    (out_even),
      .out_odd     (out_odd),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .bram_en     (bram_en),
      .bram_we     (bram_we),
      .bram_addr_a (bram_addr_a),
      .bram_addr_b (bram_addr_b),
      .bram_di_a   (bram_di_a),
      .bram_di_b   (bram_di_b),
      .bram_do_a   (bram_do_a),
      .bram_rst    (bram_rst)
   );

   always #5 clk = ~clk;

   // Dual-port banks, 1-cycle read latency, output held while disabled.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (bram_en[b]) begin
            if (bram_we[b]) begin
               mem[b][bram_addr_a[b]] <= bram_di_a[b];
               mem[b][bram_addr_b[b]] <= bram_di_b[b];
            end
            bram_do_a[b] <= mem[b][bram_addr_a[b]];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       out_ready = !out_ready;
            2:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (reset_n && out_valid) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_output: got %0d/%0d, expected no output", out_even, out_odd);
         end else begin
            checkOutput("out_even", out_even, exp_q[0].ev);
            checkOutput("out_odd", out_odd, exp_q[0].od);
            if (out_ready) begin
               if (cap_idx < DEPTH) begin
                  cap[2*cap_idx]   = out_even;
                  cap[2*cap_idx+1] = out_odd;
               end
               cap_idx++;
               void'(exp_q.pop_front());
            end
         end
      end
      if (reset_n && (|bram_we[1:0])) checkOutput("we_load_phase", DW'(in_ready), 1);
      if (reset_n && err) err_seen++;
   end

   // Reference: coefficient i moves to (i*k) mod 2N, folding with negation when >= N.
   task automatic computeModel(input int kk, input logic [DW-1:0] m);
      logic [DW-1:0] ref_out [N];
      int p;
      for (int i = 0; i < N; i++) begin
         p = (i * kk) % (2 * N);
         if (p >= N) ref_out[p-N] = (coef[i] == 0) ? '0 : (m - coef[i]);
         else        ref_out[p]   = coef[i];
      end
      for (int j = 0; j < DEPTH; j++) exp_q.push_back('{ev: ref_out[2*j], od: ref_out[2*j+1]});
   endtask

   task automatic startJob(input logic [KW-1:0] k, input logic [DW-1:0] m);
      start = 1'b1;
      galois_k = k;
      modulus = m;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic loadCoeffs(input bit inject);
      int  j = 0;
      int  guard = 0;
      bit  acc;
      bit  injected = 0;
      while (j < DEPTH && guard < 4000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_even  = coef[2*j];
         in_odd   = coef[2*j+1];
         start    = inject && !injected && (j == 10);
         if (start) begin
            galois_k = KW'(6);
            injected = 1;
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (acc) j++;
         guard++;
      end
      in_valid = 1'b0;
      checkOutput("load_beats", DW'(j), DW'(DEPTH));
   endtask

   task automatic waitDone();
      bit seen = 0;
      for (int c = 0; c < 4000 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      checkOutput("done_pulse", DW'(seen), 1);
      checkOutput("busy_after_done", DW'(busy), 0);
      checkOutput("queue_drained", DW'(exp_q.size()), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      checkOutput("done_one_cycle", DW'(done), 0);
   endtask

   task automatic applyStimulus(input logic [KW-1:0] k, input logic [DW-1:0] m, input bit inject);
      computeModel(int'(k), m);
      cap_idx = 0;
      startJob(k, m);
      checkOutput("in_ready_load", DW'(in_ready), 1);
      checkOutput("busy_load", DW'(busy), 1);
      loadCoeffs(inject);
      waitDone();
   endtask

   task automatic fillRandom(input logic [DW-1:0] m);
      for (int i = 0; i < N; i++) begin
         coef[i] = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, int'(m) - 1));
      end
   endtask

   initial begin
      logic [KW-1:0] rk;
      logic [DW-1:0] rm;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", DW'(busy), 0);
      checkOutput("rst_in_ready", DW'(in_ready), 0);
      checkOutput("rst_out_valid", DW'(out_valid), 0);
      checkOutput("rst_done", DW'(done), 0);
      checkOutput("rst_err", DW'(err), 0);
      checkOutput("rst_bram_en", DW'(bram_en), 0);
      checkOutput("rst_bram_we", DW'(bram_we), 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("bram_rst_first", DW'(bram_rst), 1);
      @(posedge clk);
      #1;
      checkOutput("bram_rst_cleared", DW'(bram_rst), 0);

      $display("[TB] even k start is rejected");
      startJob(KW'(4), 32'd97);
      expected_err++;
      checkOutput("err_even_k", DW'(err), 1);
      checkOutput("busy_even_k", DW'(busy), 0);
      @(posedge clk);
      #1;
      checkOutput("err_one_cycle", DW'(err), 0);
      checkOutput("busy_stays_idle", DW'(busy), 0);

      $display("[TB] identity k=1");
      for (int i = 0; i < N; i++) coef[i] = DW'(i + 1);
      ready_mode = 0;
      applyStimulus(KW'(1), 32'd12289, 0);
      checkOutput("k1_idx0", cap[0], 1);
      checkOutput("k1_idx255", cap[255], 256);

      $display("[TB] k=511 modulus 97");
      fillRandom(32'd97);
      coef[0] = 32'd7;
      coef[1] = 32'd5;
      ready_mode = 2;
      applyStimulus(KW'(511), 32'd97, 0);
      checkOutput("k511_idx0", cap[0], 7);
      checkOutput("k511_idx255", cap[255], 92);
      for (int i = 2; i < 6; i++) begin
         checkOutput("k511_neg", cap[256-i], (coef[i] == 0) ? '0 : (32'd97 - coef[i]));
      end

      $display("[TB] k=3 with toggling out_ready and a start during LOAD");
      fillRandom(32'd12289);
      coef[100] = 32'd9;
      coef[101] = 32'd0;
      ready_mode = 1;
      applyStimulus(KW'(3), 32'd12289, 1);
      checkOutput("k3_idx44", cap[44], 32'd12289 - 32'd9);
      checkOutput("k3_zero47", cap[47], 0);
      checkOutput("err_count", DW'(err_seen), DW'(expected_err));

      $display("[TB] reset during AUTO");
      fillRandom(32'd12289);
      ready_mode = 0;
      startJob(KW'(1), 32'd12289);
      loadCoeffs(0);
      repeat (20) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("abort_busy", DW'(busy), 0);
      checkOutput("abort_we", DW'(bram_we), 0);
      checkOutput("abort_en", DW'(bram_en), 0);
      checkOutput("abort_out_valid", DW'(out_valid), 0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("abort_we_held", DW'(bram_we), 0);
      end
      reset_n = 1'b1;
      #1;
      checkOutput("bram_rst_again", DW'(bram_rst), 1);
      @(posedge clk);
      #1;
      checkOutput("bram_rst_again_clr", DW'(bram_rst), 0);
      fillRandom(32'd12289);
      applyStimulus(KW'(1), 32'd12289, 0);

      $display("[TB] random odd k jobs");
      for (int t = 0; t < 2; t++) begin
         rk = KW'($urandom) | KW'(1);
         rm = DW'($urandom_range(1000, 32'h0fff_ffff));
         fillRandom(rm);
         ready_mode = 2;
         applyStimulus(rk, rm, 0);
      end

      checkOutput("err_count_final", DW'(err_seen), DW'(expected_err));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/automorphism_bram_ctrl.md
AUTOMORPHISM_BRAM_CTRL -- requirements
Module: automorphism_bram_ctrl

Interface
REQ-001 SHALL have parameter DLEN, default 32, coefficient width.
REQ-002 SHALL have parameter HLEN, default 7, bank address width; DEPTH=2^HLEN, N=2*DEPTH coefficients, KW=HLEN+2.
REQ-003 SHALL have port clk input 1, the single clock.
REQ-004 SHALL have port reset_n input 1, asynchronous active-low reset.
REQ-005 SHALL have ports start input 1, galois_k input KW, modulus input DLEN; k and modulus are latched on accepted start.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_even/in_odd input DLEN, carrying coefficients 2j and 2j+1 in ascending j.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, out_even/out_odd output DLEN, the permuted coefficient pair.
REQ-008 SHALL have ports busy output 1, done output 1 (one-cycle pulse), err output 1 (one-cycle pulse).
REQ-009 SHALL have bank ports bram_en[4], bram_we[4], bram_addr_a[4]/bram_addr_b[4] (HLEN), bram_di_a[4]/bram_di_b[4] (DLEN) as outputs, and bram_do_a[4] (DLEN) as input, plus bram_rst output 1; banks have 1-cycle read latency, en gates both ports, and do holds while en=0.

Function
REQ-010 SHALL implement FSM IDLE -> LOAD -> AUTO -> OUT -> IDLE; busy=1 in every state except IDLE.
REQ-011 In IDLE, start with galois_k[0]=1 SHALL enter LOAD; start with even k SHALL stay in IDLE and pulse err; start while busy SHALL be ignored.
REQ-012 In LOAD, in_ready=1; each in_valid beat SHALL write in_even to bank0[j] and in_odd to bank1[j]; after DEPTH beats -> AUTO.
REQ-013 On every write, addr_b SHALL equal addr_a and di_b SHALL equal di_a for that bank, since we applies to both ports.
REQ-014 In AUTO, the block SHALL read bank0/bank1 port a at j=0..DEPTH-1, one address per cycle, for source indices i=2j and 2j+1.
REQ-015 Destination SHALL be p=(i*k) mod 2N, computed incrementally without a multiplier: p_even starts at 0, p_odd starts at k; each advances by 2k mod 2N per step.
REQ-016 If p>=N, the coefficient SHALL be negated to (x==0 ? 0 : modulus-x) and written at index p-N; otherwise x is written at p.
REQ-017 Even sources SHALL write bank2 and odd sources bank3, both at address dest>>1; parity is preserved because k is odd and N is even.
REQ-018 AUTO SHALL be a 2-stage pipeline (read, then register/negate/write) and SHALL take DEPTH+2 cycles, after which -> OUT.
REQ-019 In OUT, advance=!out_valid||out_ready; on advance, bram_en[2]/[3] SHALL assert with addr=rd_ptr, and out_valid<= (rd_ptr<DEPTH).
REQ-020 out_even/out_odd SHALL be bram_do_a[2]/[3] and SHALL stay stable while out_valid && !out_ready.
REQ-021 After the DEPTH-th accepted output, the FSM SHALL return to IDLE and pulse done; maximum throughput is one pair per cycle.
REQ-022 bram_we SHALL never be asserted outside LOAD (banks 0/1) or AUTO (banks 2/3).

Reset
REQ-023 reset_n low SHALL asynchronously force IDLE and zero all counters, in_ready, out_valid, busy, done, err, bram_en and bram_we.
REQ-024 bram_rst SHALL be 1 for exactly the first cycle after reset_n deasserts, then 0.
REQ-025 Reset mid-operation SHALL abandon the job, and the next start SHALL run a full LOAD; bank contents are not cleared.

Structure
REQ-026 State enum and DEPTH/N/KW constants SHALL live in shared package automorphism_pkg.
REQ-027 Modular negation SHALL be sub-module mod_negate (combinational, DLEN-wide).

Verification
REQ-028 k=1, input coeff i=i+1 -> output identical to input, done after DEPTH accepted beats.
REQ-029 k=511, modulus=97, coeff1=5, coeff0=7 -> out index0=7, index255=92, and every index 256-i equals 97-coeff i.
REQ-030 k=3, coeff 100=9 -> p=300>=256 -> index44=modulus-9; a coeff of 0 at the negated position -> output 0.
REQ-031 out_ready toggling 1/0 every cycle during OUT -> no lost or duplicated pairs, data stable while stalled.
REQ-032 reset_n low during AUTO -> IDLE next edge, busy=0, no bram_we; a following start with k=1 produces correct identity output.
REQ-033 start with k=4 -> err pulse, busy stays 0; start during LOAD -> ignored.
